stoch_signed_decode: RTL and testbench
======================================

Name: stoch_signed_decode

Overview:
- Decodes a signed-channel stochastic number (a_p, a_m bitstreams) into a signed fixed-point integer.
- Counts ones on each channel over a window of N = 2**WINDOW_BITS enabled samples and outputs count_p - count_m.
- Sits at the boundary where stochastic datapaths (add/sub/mult trees) return results to binary logic or to test harnesses.
- Mirrors the signed stochastic encoder.

Parameters:
- WINDOW_BITS, 8, log2 of window length N; N = 2**WINDOW_BITS enabled samples per window.
- CONTINUOUS, 0, 1 = restart a new window immediately after each completes; 0 = return to IDLE and wait for start.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- nRST  input  1  asynchronous, active-low reset.
- start  input  1  begins a window when sampled in IDLE; ignored otherwise.
- en  input  1  sample qualifier; a_p/a_m are counted only on cycles with en=1 in ACCUM.
- a_p  input  1  positive-channel stochastic bit.
- a_m  input  1  negative-channel stochastic bit.
- y  output  WINDOW_BITS+2  signed two's-complement result, range [-N, +N].
- y_valid  output  1  one-cycle pulse when y is updated.
- busy  output  1  high while in ACCUM.

Behaviour:
- Reset (nRST=0, asynchronous): state=IDLE, count_p=count_m=0, sample counter=0, y=0, y_valid=0, busy=0.
- Reset mid-window discards all partial counts.
- States: IDLE and ACCUM.
- IDLE -> ACCUM on start=1. At that edge, count_p, count_m and the sample counter are cleared. a_p/a_m on the start cycle are NOT counted.
- ACCUM, en=0: all counters hold; stream stalls without loss.
- ACCUM, en=1: count_p += a_p, count_m += a_m, sample counter += 1.
- a_p=a_m=1 in the same cycle increments both counts; net contribution is 0.
- Window end: the cycle in ACCUM with en=1 and sample counter = N-1 completes the window. At that edge:
  - y <= (count_p + a_p) - (count_m + a_m), zero-extended to WINDOW_BITS+2 bits before subtraction.
  - y_valid=1 for exactly the following cycle.
- Latency: y_valid asserts 1 cycle after the final sample.
- After window end, CONTINUOUS=0: next state IDLE, busy=0. A start in the y_valid cycle is accepted.
- After window end, CONTINUOUS=1: counters clear at the same edge and state remains ACCUM. The next enabled cycle is sample 0 of the new window; no samples are dropped between windows.
- y holds its last value until the next window completes. y_valid is 0 at all other times.
- start while in ACCUM: ignored.
- Width rules:
  - count_p and count_m are WINDOW_BITS+1 bits; they reach N, never overflow.
  - Sample counter is WINDOW_BITS bits and wraps to 0 at window end.
  - Extremes: y = +N (all a_p=1, a_m=0) and y = -N (all a_m=1, a_p=0) are both representable.
- busy = (state == ACCUM).

Decomposition:
- Shared stochastic package:
  - state enum typedef {IDLE, ACCUM}.
  - Function returning the y width from WINDOW_BITS.
- Sub-module stoch_bit_counter: WIDTH parameter; inputs clr, inc_en, bit; output count. Instantiated twice, once for a_p and once for a_m.
- Top level holds the FSM, sample counter and output subtraction register.

Test Plan:
- WINDOW_BITS=4, start, 16 enabled cycles with a_p=1, a_m=0 -> y=+16 (6'b010000), y_valid pulses one cycle after the 16th sample, busy then 0.
- Same with a_p=0, a_m=1 -> y=-16 (6'b110000). With a_p=a_m=1 every cycle -> y=0.
- Over 16 samples: a_p high on 8, a_m high on 4, non-overlapping, en=1 every cycle -> y=+4. Repeat with en toggling 1/0 over 32 cycles, stream bits held at garbage on en=0 cycles -> still y=+4, window closes after the 16th enabled sample.
- Assert nRST asynchronously after 7 samples, release, start again, 16 samples of a_p=1 -> y=+16; y=0 and y_valid=0 while in reset. start pulsed mid-window -> no effect on the count.
- CONTINUOUS=1: start once, then 48 back-to-back enabled cycles with patterns giving +16, -16, 0 -> three y_valid pulses exactly 16 cycles apart with those values; busy stays 1 throughout.

Source files
------------

// File: rtl/stoch_signed_decode_pkg.sv
// ============================================================================
// stoch_signed_decode_pkg : shared types and helpers for the signed decoder
// Revision: 1.0
// ============================================================================
`default_nettype none

package stoch_signed_decode_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Result width: enough for the full range [-N, +N] with N = 2**window_bits.
  function automatic int y_width(input int window_bits);
    return window_bits + 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stoch_bit_counter.sv
// ============================================================================
// stoch_bit_counter : counts ones on a single stochastic bitstream
// Revision: 1.0
// ============================================================================
`default_nettype none

module stoch_bit_counter #(
  parameter int WIDTH = 9
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             clr_i,
  input  logic             inc_en_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Clear wins over increment so a new window starts from zero.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_en_i && bit_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/stoch_signed_decode.sv
// ============================================================================
// stoch_signed_decode : windowed decode of a signed stochastic pair to integer
// Revision: 1.0
// ============================================================================
`default_nettype none

module stoch_signed_decode
  import stoch_signed_decode_pkg::*;
#(
  parameter int WINDOW_BITS = 8,
  parameter bit CONTINUOUS  = 1'b0
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   start,
  input  logic                   en,
  input  logic                   a_p,
  input  logic                   a_m,
  output logic [WINDOW_BITS+1:0] y,
  output logic                   y_valid,
  output logic                   busy
);

  localparam int CW = WINDOW_BITS + 1;
  localparam int YW = y_width(WINDOW_BITS);
  localparam logic [WINDOW_BITS-1:0] LAST_SMP = '1;

  state_e                 state_q, state_d;
  logic [WINDOW_BITS-1:0] smp_q, smp_d;
  logic [YW-1:0]          y_q, y_d;
  logic                   y_valid_q, y_valid_d;

  logic                   cnt_clr;
  logic                   cnt_inc;
  logic [CW-1:0]          cnt_p;
  logic [CW-1:0]          cnt_m;
  logic [YW-1:0]          pos_total;
  logic [YW-1:0]          neg_total;
  logic [YW-1:0]          diff;

  stoch_bit_counter #(
    .WIDTH (CW)
  ) u_cnt_p (
    .CLK      (CLK),
    .nRST     (nRST),
    .clr_i    (cnt_clr),
    .inc_en_i (cnt_inc),
    .bit_i    (a_p),
    .count_o  (cnt_p)
  );

  stoch_bit_counter #(
    .WIDTH (CW)
  ) u_cnt_m (
    .CLK      (CLK),
    .nRST     (nRST),
    .clr_i    (cnt_clr),
    .inc_en_i (cnt_inc),
    .bit_i    (a_m),
    .count_o  (cnt_m)
  );

  // The final sample is folded in here since the counters only see it after the edge.
  assign pos_total = {1'b0, cnt_p} + {{(YW-1){1'b0}}, a_p};
  assign neg_total = {1'b0, cnt_m} + {{(YW-1){1'b0}}, a_m};
  assign diff      = pos_total - neg_total;

  always_comb begin
    state_d   = state_q;
    smp_d     = smp_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          smp_d   = '0;
          cnt_clr = 1'b1;
        end
      end
      ACCUM: begin
        if (en) begin
          cnt_inc = 1'b1;
          smp_d   = smp_q + WINDOW_BITS'(1);
          if (smp_q == LAST_SMP) begin
            y_d       = diff;
            y_valid_d = 1'b1;
            smp_d     = '0;
            if (CONTINUOUS) begin
              cnt_clr = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      smp_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      smp_q     <= smp_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign busy    = (state_q == ACCUM);

endmodule

`default_nettype wire

// File: tb/tb_stoch_signed_decode.sv
// Self-checking bench: two decoders (single-shot and continuous), WINDOW_BITS=4.
`default_nettype none

module tb_stoch_signed_decode;

  localparam int WB = 4;
  localparam int N  = 16;

  logic CLK;
  logic nRST;
  logic start0, en0, ap0, am0;
  logic start1, en1, ap1, am1;
  logic [WB+1:0] y0, y1;
  logic yv0, yv1, busy0, busy1;

  int checks   = 0;
  int failures = 0;

  stoch_signed_decode #(.WINDOW_BITS(WB), .CONTINUOUS(1'b0)) dut0 (
    .CLK(CLK), .nRST(nRST), .start(start0), .en(en0), .a_p(ap0), .a_m(am0),
    .y(y0), .y_valid(yv0), .busy(busy0)
  );

  stoch_signed_decode #(.WINDOW_BITS(WB), .CONTINUOUS(1'b1)) dut1 (
    .CLK(CLK), .nRST(nRST), .start(start1), .en(en1), .a_p(ap1), .a_m(am1),
    .y(y1), .y_valid(yv1), .busy(busy1)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Behavioural model: integer tallies of the samples in the current window.
  typedef struct {
    bit active;
    int sp;
    int sm;
    int k;
    int y;
    bit v;
  } model_t;

  model_t m0, m1;

  function automatic model_t mreset();
    model_t r;
    r.active = 0; r.sp = 0; r.sm = 0; r.k = 0; r.y = 0; r.v = 0;
    return r;
  endfunction

  function automatic model_t mstep(model_t m, bit cont, bit st, bit e, bit p, bit q);
    model_t n = m;
    n.v = 0;
    if (!m.active) begin
      if (st) begin
        n.active = 1; n.sp = 0; n.sm = 0; n.k = 0;
      end
    end else if (e) begin
      n.sp += int'(p);
      n.sm += int'(q);
      n.k  += 1;
      if (n.k == N) begin
        n.y = n.sp - n.sm;
        n.v = 1;
        n.sp = 0; n.sm = 0; n.k = 0;
        n.active = cont;
      end
    end
    return n;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock, keep the model in step, and compare both DUTs to it.
  task automatic tick();
    if (!nRST) begin
      m0 = mreset();
      m1 = mreset();
    end else begin
      m0 = mstep(m0, 1'b0, start0, en0, ap0, am0);
      m1 = mstep(m1, 1'b1, start1, en1, ap1, am1);
    end
    @(posedge CLK);
    #1;
    check("model_y0",    int'($signed(y0)), m0.y);
    check("model_yv0",   int'(yv0),         int'(m0.v));
    check("model_busy0", int'(busy0),       int'(m0.active));
    check("model_y1",    int'($signed(y1)), m1.y);
    check("model_yv1",   int'(yv1),         int'(m1.v));
    check("model_busy1", int'(busy1),       int'(m1.active));
  endtask

  typedef struct {
    logic [15:0] ap;
    logic [15:0] am;
    int          exp_y;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [15:0] pp, pm;
    int pulse_at [3];
    int pulse_y  [3];
    int npulse;
    bit busy_dropped;

    tbl[0] = '{16'hFFFF, 16'h0000,  16};
    tbl[1] = '{16'h0000, 16'hFFFF, -16};
    tbl[2] = '{16'hFFFF, 16'hFFFF,   0};
    tbl[3] = '{16'h00FF, 16'h0F00,   4};
    tbl[4] = '{16'hAAAA, 16'h5555,   0};
    tbl[5] = '{16'hFFFF, 16'h0001,  15};
    tbl[6] = '{16'h0001, 16'h0000,   1};

    m0 = mreset();
    m1 = mreset();
    nRST = 1'b0;
    start0 = 0; en0 = 0; ap0 = 0; am0 = 0;
    start1 = 0; en1 = 0; ap1 = 0; am1 = 0;

    // Reset state
    tick();
    tick();
    check("rst_y0", int'(y0), 0);
    check("rst_yv0", int'(yv0), 0);
    check("rst_busy0", int'(busy0), 0);
    nRST = 1'b1;
    tick();

    // Table-driven windows on the single-shot decoder
    for (int t = 0; t < 7; t++) begin
      pp = tbl[t].ap;
      pm = tbl[t].am;
      start0 = 1; ap0 = 1; am0 = 0;   // start-cycle bits must not be counted
      tick();
      start0 = 0;
      check("tbl_busy_after_start", int'(busy0), 1);
      for (int i = 0; i < N; i++) begin
        en0 = 1; ap0 = pp[i]; am0 = pm[i];
        tick();
        if (i == N - 2) check("tbl_no_early_valid", int'(yv0), 0);
      end
      en0 = 0; ap0 = 0; am0 = 0;
      check("tbl_valid", int'(yv0), 1);
      check("tbl_y", int'($signed(y0)), tbl[t].exp_y);
      check("tbl_busy_done", int'(busy0), 0);
      tick();
      check("tbl_valid_pulse_width", int'(yv0), 0);
      check("tbl_y_hold", int'($signed(y0)), tbl[t].exp_y);
    end

    // en toggling with garbage on disabled cycles: +4 after 16 enabled samples
    pp = 16'h00FF;
    pm = 16'h0F00;
    start0 = 1;
    tick();
    start0 = 0;
    for (int c = 0; c < 2 * N; c++) begin
      en0 = (c % 2 == 0);
      if (en0) begin
        ap0 = pp[c/2]; am0 = pm[c/2];
      end else begin
        ap0 = 1'($urandom); am0 = 1'($urandom);
      end
      tick();
      if (c == 2 * N - 3) check("stall_no_early_valid", int'(yv0), 0);
      if (c == 2 * N - 2) begin
        check("stall_valid", int'(yv0), 1);
        check("stall_y", int'($signed(y0)), 4);
        start0 = 1;                     // start in the y_valid cycle is accepted
      end
      if (c == 2 * N - 1) begin
        check("start_in_valid_cycle", int'(busy0), 1);
        start0 = 0;
      end
    end
    en0 = 0;

    // Asynchronous reset mid-window, then a clean window with a stray start
    for (int i = 0; i < 7; i++) begin
      en0 = 1; ap0 = 0; am0 = 1;
      tick();
    end
    en0 = 0;
    #2;
    nRST = 1'b0;
    #1;
    check("async_rst_y", int'(y0), 0);
    check("async_rst_yv", int'(yv0), 0);
    check("async_rst_busy", int'(busy0), 0);
    m0 = mreset();
    m1 = mreset();
    tick();
    nRST = 1'b1;
    start0 = 1;
    tick();
    start0 = 0;
    for (int i = 0; i < N; i++) begin
      en0 = 1; ap0 = 1; am0 = 0;
      start0 = (i == 8);
      tick();
    end
    start0 = 0; en0 = 0; ap0 = 0;
    check("post_rst_valid", int'(yv0), 1);
    check("post_rst_y", int'($signed(y0)), 16);

    // Continuous mode: three back-to-back windows of +16, -16, 0
    npulse = 0;
    busy_dropped = 0;
    start1 = 1;
    tick();
    start1 = 0;
    for (int i = 0; i < 3 * N; i++) begin
      en1 = 1;
      ap1 = (i < N) || (i >= 2 * N);
      am1 = (i >= N);
      tick();
      if (!busy1) busy_dropped = 1;
      if (yv1) begin
        if (npulse < 3) begin
          pulse_at[npulse] = i;
          pulse_y[npulse]  = int'($signed(y1));
        end
        npulse++;
      end
    end
    en1 = 0; ap1 = 0; am1 = 0;
    check("cont_pulse_count", npulse, 3);
    check("cont_busy_steady", int'(busy_dropped), 0);
    if (npulse == 3) begin
      check("cont_first_pulse", pulse_at[0], N - 1);
      check("cont_spacing_1", pulse_at[1] - pulse_at[0], N);
      check("cont_spacing_2", pulse_at[2] - pulse_at[1], N);
      check("cont_y_pos", pulse_y[0], 16);
      check("cont_y_neg", pulse_y[1], -16);
      check("cont_y_zero", pulse_y[2], 0);
    end

    // Randomized traffic on both decoders against the model
    for (int c = 0; c < 900; c++) begin
      start0 = ($urandom_range(0, 5) == 0);
      en0    = ($urandom_range(0, 3) != 0);
      ap0    = 1'($urandom);
      am0    = 1'($urandom);
      start1 = ($urandom_range(0, 9) == 0);
      en1    = ($urandom_range(0, 4) != 0);
      ap1    = 1'($urandom);
      am1    = 1'($urandom);
      nRST   = !(c == 450 || c == 451);
      tick();
    end
    nRST = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
